// File: rtl/dmem_arbiter.sv
// Arbitrates an instruction fetch port and a data port onto a single memory port (IDLE/ACCESS/RESP).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the data port has fixed priority.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mreq,
  output logic [31:0] addr,
  output logic        write,
  output logic [1:0]  access_size,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  input  logic        mem_ready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic        grantD_q, grantD_d;
  logic [31:0] iRdata_q, iRdata_d;
  logic [31:0] dRdata_q, dRdata_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic        err_q, err_d;
  logic        pickData;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic lastInstr_q, lastInstr_d;

  // On contention the port not served most recently wins; reset treats the instruction port as last served.
  assign pickData = d_req && (!i_req || lastInstr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastInstr_q <= 1'b1;
    end else begin
      lastInstr_q <= lastInstr_d;
    end
  end

  always_comb begin
    lastInstr_d = lastInstr_q;
    if (state_q == IDLE && (i_req || d_req)) begin
      lastInstr_d = !pickData;
    end
  end
`else
  assign pickData = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      wdata_q   <= '0;
      grantD_q  <= 1'b0;
      iRdata_q  <= '0;
      dRdata_q  <= '0;
      waitCnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      grantD_q  <= grantD_d;
      iRdata_q  <= iRdata_d;
      dRdata_q  <= dRdata_d;
      waitCnt_q <= waitCnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    grantD_d  = grantD_q;
    iRdata_d  = iRdata_q;
    dRdata_d  = dRdata_q;
    waitCnt_d = waitCnt_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d   = ACCESS;
          waitCnt_d = '0;
          grantD_d  = pickData;
          if (pickData) begin
            addr_d  = d_addr;
            write_d = d_write;
            size_d  = d_size;
            wdata_d = d_wdata;
          end else begin
            addr_d  = i_addr;
            write_d = 1'b0;
            size_d  = 2'b10;
            wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        // A ready response in the final allowed cycle beats the timeout.
        if (mem_ready) begin
          state_d = RESP;
          if (grantD_q) dRdata_d = rd_data;
          else          iRdata_d = rd_data;
        end else if (waitCnt_q == WAIT_LAST) begin
          state_d   = RESP;
          waitCnt_d = waitCnt_q + 8'd1;
          err_d     = 1'b1;
          if (grantD_q) dRdata_d = '0;
          else          iRdata_d = '0;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mreq        = (state_q == ACCESS);
  assign addr        = addr_q;
  assign write       = write_q;
  assign access_size = size_q;
  assign wr_data     = wdata_q;
  assign i_ack       = (state_q == RESP) && !grantD_q;
  assign d_ack       = (state_q == RESP) && grantD_q;
  assign i_rdata     = iRdata_q;
  assign d_rdata     = dRdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, contention/reset sequences,
// and randomized transactions checked against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_write = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mreq;
  logic [31:0] addr;
  logic        write;
  logic [1:0]  access_size;
  logic [31:0] wr_data;
  logic [31:0] rd_data = '0;
  logic        mem_ready = 1'b0;
  logic        err;

  int tests = 0;
  int failures = 0;

  // Requester-side state: a pending request keeps its fields until it is acknowledged.
  logic        iPend = 1'b0, dPend = 1'b0;
  logic [31:0] iAddrCur = '0, dAddrCur = '0, dWdataCur = '0;
  logic        dWriteCur = 1'b0;
  logic [1:0]  dSizeCur = '0;

  // Reference model state.
  logic [31:0] iRdataM = '0, dRdataM = '0;
  logic        lastWasI = 1'b1;
  logic        errM = 1'b0;

  typedef struct {
    logic        iReq;
    logic        dReq;
    logic [31:0] iAddr;
    logic [31:0] dAddr;
    logic        dWrite;
    logic [1:0]  dSize;
    logic [31:0] dWdata;
    logic [31:0] memWord;
    int          delay;
    logic        expD;
    int          expCycles;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[6];

  dmem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mreq(mreq), .addr(addr), .write(write), .access_size(access_size),
    .wr_data(wr_data), .rd_data(rd_data), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; rd_data = '0;
    iPend = 1'b0; dPend = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_mreq",   32'(mreq), 32'h0);
    checkOutput("rst_write",  32'(write), 32'h0);
    checkOutput("rst_iAck",   32'(i_ack), 32'h0);
    checkOutput("rst_dAck",   32'(d_ack), 32'h0);
    checkOutput("rst_err",    32'(err), 32'h0);
    checkOutput("rst_addr",   addr, 32'h0);
    checkOutput("rst_size",   32'(access_size), 32'h0);
    checkOutput("rst_wdata",  wr_data, 32'h0);
    checkOutput("rst_iRdata", i_rdata, 32'h0);
    checkOutput("rst_dRdata", d_rdata, 32'h0);
    iRdataM = '0; dRdataM = '0; lastWasI = 1'b1; errM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents the pending requests in an IDLE cycle, plays the memory with the given
  // number of wait cycles, and checks the granted transaction end to end.
  task automatic applyStimulus(input string name, input int delay, input logic [31:0] memWord,
                               input logic expD, input int expCycles,
                               input logic [31:0] expRdata, input logic expErr);
    int  accessCycles = 0;
    int  cyc = 0;
    bit  done = 1'b0;
    @(negedge clk);
    checkOutput({name, "_idleMreq"}, 32'(mreq), 32'h0);
    checkOutput({name, "_idleAcks"}, 32'({i_ack, d_ack}), 32'h0);
    i_req = iPend; i_addr = iAddrCur;
    d_req = dPend; d_addr = dAddrCur; d_write = dWriteCur; d_size = dSizeCur; d_wdata = dWdataCur;
    mem_ready = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mreq) begin
        accessCycles++;
        checkOutput({name, "_addr"},  addr,    expD ? dAddrCur : iAddrCur);
        checkOutput({name, "_write"}, 32'(write), expD ? 32'(dWriteCur) : 32'h0);
        checkOutput({name, "_size"},  32'(access_size), expD ? 32'(dSizeCur) : 32'h2);
        checkOutput({name, "_wdata"}, wr_data, expD ? dWdataCur : 32'h0);
        mem_ready = (accessCycles == delay + 1);
        rd_data   = mem_ready ? memWord : $urandom();
      end else begin
        mem_ready = 1'b0;
      end
      if (i_ack || d_ack) begin
        done = 1'b1;
        checkOutput({name, "_dAck"}, 32'(d_ack), 32'(expD));
        checkOutput({name, "_iAck"}, 32'(i_ack), 32'(!expD));
        checkOutput({name, "_accessCycles"}, 32'(accessCycles), 32'(expCycles));
        checkOutput({name, "_ackLatency"}, 32'(cyc), 32'(expCycles + 1));
        if (expD) dRdataM = expRdata;
        else      iRdataM = expRdata;
        checkOutput({name, "_iRdata"}, i_rdata, iRdataM);
        checkOutput({name, "_dRdata"}, d_rdata, dRdataM);
        checkOutput({name, "_err"}, 32'(err), 32'(expErr));
        lastWasI = !expD;
        if (expD) begin dPend = 1'b0; d_req = 1'b0; end
        else      begin iPend = 1'b0; i_req = 1'b0; end
      end
    end
    if (!done) checkOutput({name, "_ackTimeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    vec_t        v;
    logic [3:0]  rrPattern;
    logic        expD;
    int          delay;
    logic [31:0] word;

    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,   1'b0, 2'b00, 32'h0,        32'hDEADBEEF, 0, 1'b0, 1, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0,   32'h200, 1'b1, 2'b01, 32'h12345678, 32'hCAFEF00D, 3, 1'b1, 4, 32'hCAFEF00D, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h0,   32'h300, 1'b0, 2'b10, 32'h0,        32'h0BADF00D, 1, 1'b1, 2, 32'h0BADF00D, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h104, 32'h0,   1'b0, 2'b00, 32'h0,        32'h11112222, 2, 1'b0, 3, 32'h11112222, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0,   32'h400, 1'b0, 2'b00, 32'h0,        32'h77778888, 9, 1'b1, 4, 32'h0,        1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h108, 32'h0,   1'b0, 2'b00, 32'h0,        32'h55AA55AA, 0, 1'b0, 1, 32'h55AA55AA, 1'b1};

    applyReset();

    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      iPend = v.iReq; iAddrCur = v.iAddr;
      dPend = v.dReq; dAddrCur = v.dAddr; dWriteCur = v.dWrite; dSizeCur = v.dSize; dWdataCur = v.dWdata;
      applyStimulus($sformatf("vec%0d", k), v.delay, v.memWord, v.expD, v.expCycles, v.expRdata, v.expErr);
    end

    // Both ports keep requesting for four back-to-back grants.
    applyReset();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    rrPattern = 4'b0101;
`else
    rrPattern = 4'b1111;
`endif
    for (int k = 0; k < 4; k++) begin
      if (!iPend) begin iPend = 1'b1; iAddrCur = 32'h700 + 32'(k * 4); end
      if (!dPend) begin
        dPend = 1'b1; dAddrCur = 32'h800 + 32'(k * 4);
        dWriteCur = 1'b0; dSizeCur = 2'b10; dWdataCur = '0;
      end
      word = $urandom();
      applyStimulus($sformatf("contend%0d", k), 0, word, rrPattern[k], 1, word, 1'b0);
    end
    word = $urandom();
    applyStimulus("contendDrain", 0, word, dPend, 1, word, 1'b0);

    // Reset asserted while an access is outstanding.
    @(negedge clk);
    iPend = 1'b1; iAddrCur = 32'h500; i_req = 1'b1; i_addr = 32'h500; mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("midRst_mreqBefore", 32'(mreq), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRst_mreq", 32'(mreq), 32'h0);
    checkOutput("midRst_acks", 32'({i_ack, d_ack}), 32'h0);
    checkOutput("midRst_addr", addr, 32'h0);
    i_req = 1'b0; iPend = 1'b0;
    @(negedge clk);
    checkOutput("midRst_acksHeld", 32'({i_ack, d_ack}), 32'h0);
    iRdataM = '0; dRdataM = '0; lastWasI = 1'b1; errM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    iPend = 1'b1; iAddrCur = 32'h600;
    applyStimulus("afterRst", 1, 32'hA5A5F00F, 1'b0, 2, 32'hA5A5F00F, 1'b0);

    // Randomized traffic against the transaction-level model.
    for (int k = 0; k < 60; k++) begin
      if (!iPend && $urandom_range(0, 1) == 1) begin
        iPend = 1'b1; iAddrCur = $urandom();
      end
      if (!dPend && ($urandom_range(0, 1) == 1 || !iPend)) begin
        dPend = 1'b1; dAddrCur = $urandom(); dWriteCur = 1'($urandom_range(0, 1));
        dSizeCur = 2'($urandom_range(0, 3)); dWdataCur = $urandom();
      end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      expD = (iPend && dPend) ? lastWasI : dPend;
`else
      expD = dPend;
`endif
      delay = $urandom_range(0, 5);
      word = $urandom();
      if (delay >= MAXW) errM = 1'b1;
      applyStimulus($sformatf("rand%0d", k), delay, word, expD,
                    (delay < MAXW) ? delay + 1 : MAXW,
                    (delay < MAXW) ? word : 32'h0, errM);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum ACCESS cycles without mem_ready before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have instruction-side ports: i_req input 1 (read request); i_addr input 32; i_ack output 1; i_rdata output 32.
REQ-005 SHALL have data-side ports: d_req input 1; d_addr input 32; d_write input 1; d_size input 2 (access size code); d_wdata input 32; d_ack output 1; d_rdata output 32.
REQ-006 SHALL have memory-side ports: mreq output 1; addr output 32; write output 1; access_size output 2; wr_data output 32; rd_data input 32; mem_ready input 1.
REQ-007 SHALL have port err output 1: sticky timeout flag.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-009 IDLE: if neither i_req nor d_req is high, SHALL remain in IDLE; otherwise it SHALL select one winner, register its address/write/size/wdata, and move to ACCESS on the next edge.
REQ-010 Instruction grant SHALL register write=0, access_size=2'b10, and wr_data=0.
REQ-011 ACCESS: mreq, addr, write, access_size, and wr_data SHALL be driven from registers and held constant for every ACCESS cycle.
REQ-012 ACCESS: if mem_ready is sampled high, the FSM SHALL capture rd_data into the winner's rdata register and move to RESP.
REQ-013 A cycle-count of 0 after request, with mem_ready high on the first ACCESS cycle, SHALL produce ack two cycles after the request was sampled in IDLE.
REQ-014 RESP: the winner's ack SHALL be high for exactly one cycle; mreq SHALL be 0; the FSM SHALL return to IDLE unconditionally.
REQ-015 The non-winner's ack SHALL remain 0 throughout; the loser's request SHALL stay pending and be granted on a later IDLE.
REQ-016 i_rdata/d_rdata SHALL hold their last captured value until overwritten by a later access to the same port.
REQ-017 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with mem_ready low.
REQ-018 If the wait counter reaches MAX_WAIT, the FSM SHALL abort to RESP, load 32'h0 into the winner's rdata, set err, and still pulse the winner's ack.
REQ-019 A mem_ready that is high in the same cycle the counter reaches MAX_WAIT SHALL take precedence over the timeout.
REQ-020 mreq SHALL be 1 only in ACCESS.
REQ-021 Requesters SHALL hold req and request fields stable until ack.
REQ-022 Requester inputs SHALL be ignored outside IDLE.

Reset
REQ-023 Asserting rst_n low SHALL immediately force: state IDLE, mreq=0, write=0, i_ack=0, d_ack=0, err=0, addr=0, access_size=0, wr_data=0, i_rdata=0, d_rdata=0, wait counter=0, and priority pointer = instruction-last.
REQ-024 Reset during ACCESS SHALL abandon the access with no ack.
REQ-025 After rst_n deasserts, the block SHALL sample requests on the first rising edge.

Configuration
REQ-026 With DMEM_ARB_ROUND_ROBIN_EN defined, when both requests are high in IDLE the port not granted most recently SHALL win; the pointer SHALL update on each grant.
REQ-027 Without DMEM_ARB_ROUND_ROBIN_EN, the data port SHALL always win simultaneous requests (fixed priority), and no pointer register SHALL exist.

Verification
REQ-028 i_req=1, i_addr=0x100, mem_ready high on first ACCESS cycle, rd_data=0xDEADBEEF -> mreq=1 for one cycle, write=0, access_size=2'b10, i_ack pulses 1 cycle, i_rdata=0xDEADBEEF.
REQ-029 d_req=1, d_write=1, d_addr=0x200, d_wdata=0x12345678, d_size=2'b01, mem_ready after 3 wait cycles -> mreq high 4 cycles with stable addr/wr_data/access_size, d_ack single pulse, i_ack=0.
REQ-030 i_req and d_req both held high for 4 accesses -> fixed priority: 4 data grants with i starved while d_req stays high; round-robin: grants D,I,D,I.
REQ-031 MAX_WAIT=4, mem_ready held low -> abort after 4 ACCESS cycles, ack pulses, rdata=0, err=1 until reset.
REQ-032 rst_n pulled low mid-ACCESS -> mreq=0 immediately, no ack; after release, a fresh i_req completes normally.
